// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt-acknowledge path.
// Contents: width constants, the INTA sequence state encoding, the default
// 8080 CALL opcode and the one-hot IR decode used for ISR set/clear strobes.
package pic_pkg;

    localparam int unsigned IRQ_W  = 3;
    localparam int unsigned NIRQ   = 8;
    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] CALL_OPCODE_DEF = 8'hCD;

    // P* = INTA_n low (byte pulse), G* = gap between pulses
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_G1   = 3'd2,
        ST_P2   = 3'd3,
        ST_G2   = 3'd4,
        ST_P3   = 3'd5
    } inta_state_e;

    // One-hot decode of an IR number onto the 8-bit ISR strobe vector
    function automatic logic [NIRQ-1:0] onehot8(input logic [IRQ_W-1:0] n);
        logic [NIRQ-1:0] r;
        r    = '0;
        r[n] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// INTA_n edge detector.
// Ports: clk, reset (async, active-high), inta_n_i (already synchronous),
//        fall_c / rise_c: combinational 1-cycle strobes against the registered copy.
module inta_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic inta_n_i,
    output logic fall_c,
    output logic rise_c
);

    logic inta_q;

    // Resets to the inactive (high) level so leaving reset never looks like an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inta_q <= 1'b1;
        end else begin
            inta_q <= inta_n_i;
        end
    end

    assign fall_c = inta_q & ~inta_n_i;
    assign rise_c = ~inta_q & inta_n_i;

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer.
// Counts INTA_n pulses (2 for 8086, 3 for 8080), raises ISR set / AEOI clear
// strobes, drives the master CAS code, decodes slave selection from CAS_in and
// sequences CALL / vector / address bytes onto the data bus.
// Inputs : clk, reset, INTA_n, mode_8086, SNGL, Master_Slave, ID, CAS_in,
//          slave_map, irq_valid, irq_num, vec_base, addr_lo, addr_hi, adi, aeoi
// Outputs: isr_set, eoi_auto, cas_out, cas_oe, data_out, data_oe, busy (all registered)
module inta_sequencer
    import pic_pkg::*;
#(
    parameter logic [DATA_W-1:0] CALL_OPCODE = CALL_OPCODE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              INTA_n,
    input  logic              mode_8086,
    input  logic              SNGL,
    input  logic              Master_Slave,
    input  logic [IRQ_W-1:0]  ID,
    input  logic [IRQ_W-1:0]  CAS_in,
    input  logic [NIRQ-1:0]   slave_map,
    input  logic              irq_valid,
    input  logic [IRQ_W-1:0]  irq_num,
    input  logic [4:0]        vec_base,
    input  logic [2:0]        addr_lo,
    input  logic [DATA_W-1:0] addr_hi,
    input  logic              adi,
    input  logic              aeoi,
    output logic [NIRQ-1:0]   isr_set,
    output logic [NIRQ-1:0]   eoi_auto,
    output logic [IRQ_W-1:0]  cas_out,
    output logic              cas_oe,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              busy
);

    logic fall_c;
    logic rise_c;

    inta_edge_detect u_edge (
        .clk      (clk),
        .reset    (reset),
        .inta_n_i (INTA_n),
        .fall_c   (fall_c),
        .rise_c   (rise_c)
    );

    inta_state_e       state_q;
    logic [IRQ_W-1:0]  cur_irq_q;
    logic              spurious_q;
    logic              casmode_q;
    logic              master_q;
    logic              len3_q;
    logic              sel_q;
    logic [NIRQ-1:0]   isr_set_q;
    logic [NIRQ-1:0]   eoi_auto_q;
    logic [IRQ_W-1:0]  cas_out_q;
    logic              cas_oe_q;
    logic [DATA_W-1:0] data_out_q;
    logic              data_oe_q;
    logic              busy_q;

    // Values captured at the first INTA fall
    logic [IRQ_W-1:0]  cur_irq_new;
    logic              master_new;
    logic              casmode_new;
    assign cur_irq_new = irq_valid ? irq_num : 3'd7;
    assign master_new  = SNGL | Master_Slave;
    assign casmode_new = ~SNGL & Master_Slave & slave_map[cur_irq_new];

    // Master/single owns the data bus unless a cascaded slave does; a slave owns it when selected
    logic              owner;
    logic [DATA_W-1:0] vec_byte;
    logic [DATA_W-1:0] addr_lo_byte;
    logic              eoi_fire;
    assign owner        = master_q ? ~casmode_q : sel_q;
    assign vec_byte     = {vec_base, cur_irq_q};
    assign addr_lo_byte = adi ? {addr_lo, cur_irq_q, 2'b00}
                              : {addr_lo[2:1], cur_irq_q, 3'b000};
    assign eoi_fire     = aeoi & ~spurious_q & (master_q | sel_q);

    // Acknowledge FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_irq_q  <= '0;
            spurious_q <= 1'b0;
            casmode_q  <= 1'b0;
            master_q   <= 1'b0;
            len3_q     <= 1'b0;
            sel_q      <= 1'b0;
            isr_set_q  <= '0;
            eoi_auto_q <= '0;
            cas_out_q  <= '0;
            cas_oe_q   <= 1'b0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            isr_set_q  <= '0;
            eoi_auto_q <= '0;
            case (state_q)
                ST_IDLE: if (fall_c) begin
                    state_q    <= ST_P1;
                    busy_q     <= 1'b1;
                    cur_irq_q  <= cur_irq_new;
                    spurious_q <= ~irq_valid;
                    casmode_q  <= casmode_new;
                    master_q   <= master_new;
                    len3_q     <= ~mode_8086;
                    sel_q      <= 1'b0;
                    if (master_new && irq_valid) isr_set_q <= onehot8(cur_irq_new);
                    cas_out_q  <= casmode_new ? cur_irq_new : '0;
                    cas_oe_q   <= casmode_new;
                    // 8080 CALL comes from the master even when a slave supplies later bytes
                    if (!mode_8086 && master_new) begin
                        data_out_q <= CALL_OPCODE;
                        data_oe_q  <= 1'b1;
                    end
                end
                ST_P1: if (rise_c) begin
                    state_q    <= ST_G1;
                    data_out_q <= '0;
                    data_oe_q  <= 1'b0;
                    if (!master_q) begin
                        sel_q <= (CAS_in == ID);
                        if ((CAS_in == ID) && !spurious_q) isr_set_q <= onehot8(cur_irq_q);
                    end
                end
                ST_G1: if (fall_c) begin
                    state_q    <= ST_P2;
                    data_oe_q  <= owner;
                    data_out_q <= owner ? (len3_q ? addr_lo_byte : vec_byte) : '0;
                end
                ST_P2: if (rise_c) begin
                    data_out_q <= '0;
                    data_oe_q  <= 1'b0;
                    if (len3_q) begin
                        state_q <= ST_G2;
                    end else begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        cas_out_q <= '0;
                        cas_oe_q  <= 1'b0;
                        if (eoi_fire) eoi_auto_q <= onehot8(cur_irq_q);
                    end
                end
                ST_G2: if (fall_c) begin
                    state_q    <= ST_P3;
                    data_oe_q  <= owner;
                    data_out_q <= owner ? addr_hi : '0;
                end
                ST_P3: if (rise_c) begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    cas_out_q  <= '0;
                    cas_oe_q   <= 1'b0;
                    data_out_q <= '0;
                    data_oe_q  <= 1'b0;
                    if (eoi_fire) eoi_auto_q <= onehot8(cur_irq_q);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign isr_set  = isr_set_q;
    assign eoi_auto = eoi_auto_q;
    assign cas_out  = cas_out_q;
    assign cas_oe   = cas_oe_q;
    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: inputs change 1 ns after a rising edge,
// outputs are sampled 1 ns after the following rising edge.
module tb_inta_sequencer;

    logic       clk;
    logic       reset;
    logic       INTA_n;
    logic       mode_8086;
    logic       SNGL;
    logic       Master_Slave;
    logic [2:0] ID;
    logic [2:0] CAS_in;
    logic [7:0] slave_map;
    logic       irq_valid;
    logic [2:0] irq_num;
    logic [4:0] vec_base;
    logic [2:0] addr_lo;
    logic [7:0] addr_hi;
    logic       adi;
    logic       aeoi;
    logic [7:0] isr_set;
    logic [7:0] eoi_auto;
    logic [2:0] cas_out;
    logic       cas_oe;
    logic [7:0] data_out;
    logic       data_oe;
    logic       busy;

    int vecs = 0;
    int errs = 0;

    inta_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .INTA_n       (INTA_n),
        .mode_8086    (mode_8086),
        .SNGL         (SNGL),
        .Master_Slave (Master_Slave),
        .ID           (ID),
        .CAS_in       (CAS_in),
        .slave_map    (slave_map),
        .irq_valid    (irq_valid),
        .irq_num      (irq_num),
        .vec_base     (vec_base),
        .addr_lo      (addr_lo),
        .addr_hi      (addr_hi),
        .adi          (adi),
        .aeoi         (aeoi),
        .isr_set      (isr_set),
        .eoi_auto     (eoi_auto),
        .cas_out      (cas_out),
        .cas_oe       (cas_oe),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic inta(input logic v);
        INTA_n = v;
        step();
    endtask

    task automatic cfg_defaults();
        INTA_n       = 1'b1;
        mode_8086    = 1'b1;
        SNGL         = 1'b1;
        Master_Slave = 1'b1;
        ID           = 3'd0;
        CAS_in       = 3'd0;
        slave_map    = 8'h00;
        irq_valid    = 1'b1;
        irq_num      = 3'd0;
        vec_base     = 5'h08;
        addr_lo      = 3'd0;
        addr_hi      = 8'h00;
        adi          = 1'b0;
        aeoi         = 1'b0;
    endtask

    task automatic test_reset();
        cfg_defaults();
        reset = 1'b1;
        step();
        step();
        vecs++;
        if ({isr_set, eoi_auto, cas_out, cas_oe, data_out, data_oe, busy} !== 31'd0) begin
            errs++;
            $display("FAIL reset_outputs got %h exp 0",
                     {isr_set, eoi_auto, cas_out, cas_oe, data_out, data_oe, busy});
        end
        reset = 1'b0;
        step();
        vecs++;
        if (busy !== 1'b0) begin errs++; $display("FAIL reset_release_busy got %b exp 0", busy); end
    endtask

    task automatic test_single_8086();
        cfg_defaults();
        irq_num = 3'd5;
        inta(1'b0);
        vecs++; if (isr_set !== 8'h20) begin errs++; $display("FAIL s86_p1_isr got %h exp 20", isr_set); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL s86_p1_busy got %b exp 1", busy); end
        vecs++; if (data_oe !== 1'b0) begin errs++; $display("FAIL s86_p1_doe got %b exp 0", data_oe); end
        vecs++; if (cas_oe !== 1'b0) begin errs++; $display("FAIL s86_p1_casoe got %b exp 0", cas_oe); end
        step();
        vecs++; if (isr_set !== 8'h00) begin errs++; $display("FAIL s86_isr_pulse got %h exp 00", isr_set); end
        inta(1'b1);
        irq_num = 3'd1;
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL s86_g1_busy got %b exp 1", busy); end
        inta(1'b0);
        vecs++; if (data_out !== 8'h45) begin errs++; $display("FAIL s86_p2_data got %h exp 45", data_out); end
        vecs++; if (data_oe !== 1'b1) begin errs++; $display("FAIL s86_p2_doe got %b exp 1", data_oe); end
        inta(1'b1);
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL s86_end_busy got %b exp 0", busy); end
        vecs++; if (data_oe !== 1'b0) begin errs++; $display("FAIL s86_end_doe got %b exp 0", data_oe); end
        vecs++; if (eoi_auto !== 8'h00) begin errs++; $display("FAIL s86_end_eoi got %h exp 00", eoi_auto); end
    endtask

    task automatic test_master_8080_cascade();
        cfg_defaults();
        SNGL = 1'b0; Master_Slave = 1'b1; mode_8086 = 1'b0;
        slave_map = 8'h04; irq_num = 3'd2; addr_hi = 8'h77;
        inta(1'b0);
        vecs++; if (cas_out !== 3'd2) begin errs++; $display("FAIL m80_p1_cas got %0d exp 2", cas_out); end
        vecs++; if (cas_oe !== 1'b1) begin errs++; $display("FAIL m80_p1_casoe got %b exp 1", cas_oe); end
        vecs++; if (data_out !== 8'hCD) begin errs++; $display("FAIL m80_p1_data got %h exp cd", data_out); end
        vecs++; if (data_oe !== 1'b1) begin errs++; $display("FAIL m80_p1_doe got %b exp 1", data_oe); end
        vecs++; if (isr_set !== 8'h04) begin errs++; $display("FAIL m80_p1_isr got %h exp 04", isr_set); end
        // INTA_n held low: outputs stay put
        step(); step(); step();
        vecs++; if ({cas_oe, data_oe, data_out, busy} !== {1'b1, 1'b1, 8'hCD, 1'b1}) begin
            errs++; $display("FAIL m80_hold got %b %b %h %b exp 1 1 cd 1", cas_oe, data_oe, data_out, busy);
        end
        inta(1'b1);
        vecs++; if (cas_oe !== 1'b1) begin errs++; $display("FAIL m80_g1_casoe got %b exp 1", cas_oe); end
        inta(1'b0);
        vecs++; if (data_oe !== 1'b0) begin errs++; $display("FAIL m80_p2_doe got %b exp 0", data_oe); end
        vecs++; if (cas_out !== 3'd2) begin errs++; $display("FAIL m80_p2_cas got %0d exp 2", cas_out); end
        inta(1'b1);
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL m80_g2_busy got %b exp 1", busy); end
        inta(1'b0);
        vecs++; if (data_oe !== 1'b0) begin errs++; $display("FAIL m80_p3_doe got %b exp 0", data_oe); end
        vecs++; if (cas_oe !== 1'b1) begin errs++; $display("FAIL m80_p3_casoe got %b exp 1", cas_oe); end
        inta(1'b1);
        vecs++; if ({cas_oe, cas_out, busy} !== 5'd0) begin
            errs++; $display("FAIL m80_end got %b %0d %b exp 0 0 0", cas_oe, cas_out, busy);
        end
    endtask

    task automatic test_single_8080_bytes();
        logic [7:0] exp_b2 [2];
        exp_b2[0] = 8'h98;   // adi=0: {2'b10, 3'd3, 3'b000}
        exp_b2[1] = 8'hAC;   // adi=1: {3'b101, 3'd3, 2'b00}
        for (int a = 0; a < 2; a++) begin
            cfg_defaults();
            mode_8086 = 1'b0; irq_num = 3'd3; addr_lo = 3'b101; addr_hi = 8'h9A;
            adi = (a == 1);
            inta(1'b0);
            vecs++; if (data_out !== 8'hCD) begin errs++; $display("FAIL s80_p1_data adi=%0d got %h exp cd", a, data_out); end
            inta(1'b1);
            inta(1'b0);
            vecs++; if (data_out !== exp_b2[a] || data_oe !== 1'b1) begin
                errs++; $display("FAIL s80_p2_data adi=%0d got %h/%b exp %h/1", a, data_out, data_oe, exp_b2[a]);
            end
            inta(1'b1);
            vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL s80_g2_busy adi=%0d got %b exp 1", a, busy); end
            inta(1'b0);
            vecs++; if (data_out !== 8'h9A || data_oe !== 1'b1) begin
                errs++; $display("FAIL s80_p3_data adi=%0d got %h/%b exp 9a/1", a, data_out, data_oe);
            end
            inta(1'b1);
            vecs++; if (busy !== 1'b0 || data_oe !== 1'b0) begin
                errs++; $display("FAIL s80_end adi=%0d got %b/%b exp 0/0", a, busy, data_oe);
            end
        end
    endtask

    task automatic test_slave();
        logic [2:0] cas_v  [2];
        logic [7:0] exp_is [2];
        logic [7:0] exp_d  [2];
        logic       exp_oe [2];
        cas_v[0] = 3'd3; exp_is[0] = 8'h40; exp_d[0] = 8'h46; exp_oe[0] = 1'b1;
        cas_v[1] = 3'd1; exp_is[1] = 8'h00; exp_d[1] = 8'h00; exp_oe[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cfg_defaults();
            SNGL = 1'b0; Master_Slave = 1'b0; ID = 3'd3; irq_num = 3'd6; aeoi = 1'b1;
            CAS_in = cas_v[k];
            inta(1'b0);
            vecs++; if (isr_set !== 8'h00 || cas_oe !== 1'b0) begin
                errs++; $display("FAIL slv_p1 k=%0d got %h/%b exp 00/0", k, isr_set, cas_oe);
            end
            inta(1'b1);
            vecs++; if (isr_set !== exp_is[k]) begin
                errs++; $display("FAIL slv_g1_isr k=%0d got %h exp %h", k, isr_set, exp_is[k]);
            end
            inta(1'b0);
            vecs++; if (data_oe !== exp_oe[k] || (exp_oe[k] && data_out !== exp_d[k])) begin
                errs++; $display("FAIL slv_p2 k=%0d got %h/%b exp %h/%b", k, data_out, data_oe, exp_d[k], exp_oe[k]);
            end
            inta(1'b1);
            vecs++; if (eoi_auto !== exp_is[k] || busy !== 1'b0) begin
                errs++; $display("FAIL slv_end k=%0d got %h/%b exp %h/0", k, eoi_auto, busy, exp_is[k]);
            end
        end
    endtask

    task automatic test_spurious();
        cfg_defaults();
        irq_valid = 1'b0; irq_num = 3'd2; aeoi = 1'b1;
        inta(1'b0);
        vecs++; if (isr_set !== 8'h00) begin errs++; $display("FAIL spur_isr got %h exp 00", isr_set); end
        irq_valid = 1'b1;
        inta(1'b1);
        inta(1'b0);
        vecs++; if (data_out !== 8'h47) begin errs++; $display("FAIL spur_vec got %h exp 47", data_out); end
        inta(1'b1);
        vecs++; if (eoi_auto !== 8'h00) begin errs++; $display("FAIL spur_eoi got %h exp 00", eoi_auto); end
    endtask

    task automatic test_aeoi();
        cfg_defaults();
        SNGL = 1'b0; Master_Slave = 1'b1; irq_num = 3'd0; aeoi = 1'b1;
        inta(1'b0);
        vecs++; if (isr_set !== 8'h01) begin errs++; $display("FAIL aeoi_isr got %h exp 01", isr_set); end
        inta(1'b1);
        vecs++; if (eoi_auto !== 8'h00) begin errs++; $display("FAIL aeoi_early got %h exp 00", eoi_auto); end
        inta(1'b0);
        vecs++; if (data_out !== 8'h40) begin errs++; $display("FAIL aeoi_vec got %h exp 40", data_out); end
        inta(1'b1);
        vecs++; if (eoi_auto !== 8'h01) begin errs++; $display("FAIL aeoi_pulse got %h exp 01", eoi_auto); end
        step();
        vecs++; if (eoi_auto !== 8'h00) begin errs++; $display("FAIL aeoi_width got %h exp 00", eoi_auto); end
    endtask

    task automatic test_reset_mid();
        cfg_defaults();
        SNGL = 1'b0; Master_Slave = 1'b1; mode_8086 = 1'b0; slave_map = 8'h04; irq_num = 3'd2;
        inta(1'b0);
        inta(1'b1);
        vecs++; if (cas_oe !== 1'b1 || busy !== 1'b1) begin
            errs++; $display("FAIL rmid_pre got %b/%b exp 1/1", cas_oe, busy);
        end
        reset = 1'b1;
        #2;
        vecs++; if ({isr_set, eoi_auto, cas_out, cas_oe, data_out, data_oe, busy} !== 31'd0) begin
            errs++; $display("FAIL rmid_outputs got %h exp 0",
                             {isr_set, eoi_auto, cas_out, cas_oe, data_out, data_oe, busy});
        end
        step();
        reset = 1'b0;
        step();
        // Next pulse must behave as P1: master drives CALL with cascade active
        inta(1'b0);
        vecs++; if (data_out !== 8'hCD || data_oe !== 1'b1 || cas_oe !== 1'b1 || isr_set !== 8'h04) begin
            errs++; $display("FAIL rmid_newp1 got %h/%b/%b/%h exp cd/1/1/04", data_out, data_oe, cas_oe, isr_set);
        end
        inta(1'b1);
        inta(1'b0);
        inta(1'b1);
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rmid_g2_busy got %b exp 1", busy); end
        inta(1'b0);
        inta(1'b1);
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_end_busy got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_8086();
        test_master_8080_cascade();
        test_single_8080_bytes();
        test_slave();
        test_spurious();
        test_aeoi();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
